// File: rtl/systolic_seq_ctrl.sv
// Purpose: sequences one output-stationary NxN systolic pass (clear, skewed feed, flush, drain, done).
// Latency: done_o at cycle K+3N after start when the source is always valid and the sink always ready.
// Backpressure: src_valid_i low stalls the feed without advancing the array; out_ready_i low holds the presented row.
module systolic_seq_ctrl #(
    parameter int N  = 8,
    parameter int KW = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [KW-1:0]          k_len_i,
    input  logic                   abort_i,
    input  logic                   src_valid_i,
    output logic                   src_req_o,
    output logic                   acc_clr_o,
    output logic                   shift_en_o,
    output logic [N-1:0]           feed_en_o,
    output logic                   out_valid_o,
    output logic [$clog2(N)-1:0]   out_row_o,
    input  logic                   out_ready_i,
    output logic                   drain_en_o,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int RW = $clog2(N);
    localparam int FW = $clog2(2 * N - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    // The flush must push the last injected beat through the full diagonal, 2N-2 steps.
    localparam logic [FW-1:0] FLUSH_LAST = FW'(2 * N - 3);
    localparam logic [RW-1:0] ROW_LAST   = RW'(N - 1);

    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [KW-1:0] r_k;
    logic [KW-1:0] r_beat;
    logic [FW-1:0] r_flush;
    logic [RW-1:0] r_row;
    logic [N-1:1]  r_skew;

    logic w_abort;
    logic w_start_ok;
    logic w_feed0;
    logic w_beat_last;
    logic w_flush_last;
    logic w_row_last;

    // Abort only matters once a pass is running; a start in IDLE always wins.
    assign w_abort      = abort_i && (r_state != S_IDLE);
    assign w_start_ok   = (r_state == S_IDLE) && start_i && (k_len_i != '0);
    assign w_feed0      = (r_state == S_FEED) && src_valid_i;
    assign w_beat_last  = (r_beat == (r_k - KW'(1)));
    assign w_flush_last = (r_flush == FLUSH_LAST);
    assign w_row_last   = (r_row == ROW_LAST);

    // All array controls decode straight from state so an async reset drops them at once.
    assign src_req_o            = (r_state == S_FEED);
    assign acc_clr_o            = (r_state == S_CLEAR);
    assign shift_en_o           = w_feed0 || (r_state == S_FLUSH);
    assign feed_en_o[0]         = w_feed0;
    assign feed_en_o[N-1:1]     = r_skew & {(N-1){shift_en_o}};
    assign out_valid_o          = (r_state == S_DRAIN);
    assign out_row_o            = r_row;
    assign drain_en_o           = out_valid_o && out_ready_i;
    assign busy_o               = (r_state != S_IDLE);
    assign done_o               = (r_state == S_DONE);

    // Next-state selection; abort overrides every other transition.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok) w_next = S_CLEAR;
            S_CLEAR: w_next = S_FEED;
            S_FEED:  if (src_valid_i && w_beat_last) w_next = S_FLUSH;
            S_FLUSH: if (w_flush_last) w_next = S_DRAIN;
            S_DRAIN: if (out_ready_i && w_row_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (w_abort) begin
            w_next = S_IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Pass length latch plus beat, flush and row counters; each wraps to 0 on its final count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k     <= '0;
            r_beat  <= '0;
            r_flush <= '0;
            r_row   <= '0;
        end else if (w_abort) begin
            r_beat  <= '0;
            r_flush <= '0;
            r_row   <= '0;
        end else begin
            if (w_start_ok) begin
                r_k <= k_len_i;
            end
            if (w_feed0) begin
                r_beat <= w_beat_last ? '0 : r_beat + KW'(1);
            end
            if (r_state == S_FLUSH) begin
                r_flush <= w_flush_last ? '0 : r_flush + FW'(1);
            end
            if (drain_en_o) begin
                r_row <= w_row_last ? '0 : r_row + RW'(1);
            end
        end
    end

    // Diagonal skew chain: row r sees row 0's inject pattern delayed by r shift steps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skew <= '0;
        end else if (w_abort) begin
            r_skew <= '0;
        end else if (shift_en_o) begin
            r_skew[1] <= w_feed0;
            for (int r = 2; r < N; r++) begin
                r_skew[r] <= r_skew[r-1];
            end
        end
    end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Self-checking bench for systolic_seq_ctrl (N=8, KW=4) using an event scoreboard.
module tb_systolic_seq_ctrl;

    localparam int K_ACC   = 0;
    localparam int K_FEED  = 1;
    localparam int K_BUP   = 2;
    localparam int K_BDN   = 3;
    localparam int K_DRAIN = 4;
    localparam int K_DONE  = 5;
    localparam int K_RST   = 6;

    typedef struct {
        int cyc;
        int kind;
        int val;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic       start_i;
    logic [3:0] k_len_i;
    logic       abort_i;
    logic       src_valid_i;
    logic       src_req_o;
    logic       acc_clr_o;
    logic       shift_en_o;
    logic [7:0] feed_en_o;
    logic       out_valid_o;
    logic [2:0] out_row_o;
    logic       out_ready_i;
    logic       drain_en_o;
    logic       busy_o;
    logic       done_o;

    ev_t exp_q[$];
    int  cyc = 0;
    int  t0 = 0;
    int  n_checks = 0;
    int  n_fail = 0;
    int  shift_cnt = 0;
    bit  prev_busy = 0;
    bit  end_req = 0;
    bit  end_ack = 0;

    systolic_seq_ctrl #(.N(8), .KW(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .k_len_i     (k_len_i),
        .abort_i     (abort_i),
        .src_valid_i (src_valid_i),
        .src_req_o   (src_req_o),
        .acc_clr_o   (acc_clr_o),
        .shift_en_o  (shift_en_o),
        .feed_en_o   (feed_en_o),
        .out_valid_o (out_valid_o),
        .out_row_o   (out_row_o),
        .out_ready_i (out_ready_i),
        .drain_en_o  (drain_en_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_ACC:   return "acc_clr";
            K_FEED:  return "feed_en";
            K_BUP:   return "busy_rise";
            K_BDN:   return "busy_fall";
            K_DRAIN: return "drain_row";
            K_DONE:  return "done_shifts";
            K_RST:   return "reset_outputs";
            default: return "unknown";
        endcase
    endfunction

    // ---------------- scoreboard monitor ----------------
    task automatic check_ev(input int kind, input int val);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: got event value 0x%0h at cycle %0d, required no event", kname(kind), val, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val || e.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: got %s=0x%0h at cycle %0d, required %s=0x%0h at cycle %0d",
                         kname(e.kind), kname(kind), val, cyc, kname(e.kind), e.val, e.cyc);
            end
        end
    endtask

    always begin
        @(negedge clk or negedge rst_n);
        if (clk) begin
            // reset asserted mid-cycle: outputs must already be low
            #1;
            check_ev(K_RST, int'({acc_clr_o, src_req_o, shift_en_o, feed_en_o, out_valid_o,
                                  out_row_o, drain_en_o, busy_o, done_o}));
        end else begin
            if (acc_clr_o)          check_ev(K_ACC, 0);
            if (feed_en_o != 8'h00) check_ev(K_FEED, int'(feed_en_o));
            if (busy_o && !prev_busy) check_ev(K_BUP, 0);
            if (!busy_o && prev_busy) check_ev(K_BDN, 0);
            if (drain_en_o)         check_ev(K_DRAIN, int'(out_row_o));
            if (done_o)             check_ev(K_DONE, shift_cnt);
            if (busy_o && !prev_busy) shift_cnt = int'(shift_en_o);
            else if (shift_en_o)      shift_cnt++;
            prev_busy = busy_o;
            if (end_req && !end_ack) begin
                n_checks++;
                if (exp_q.size() != 0) begin
                    n_fail++;
                    $display("FAIL leftover_events: got %0d unmatched expected events, required 0 (first %s at cycle %0d)",
                             exp_q.size(), kname(exp_q[0].kind), exp_q[0].cyc);
                end
                end_ack = 1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_ev(input int c, input int kind, input int val);
        ev_t e;
        e.cyc  = c;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic ex(input int n, input int kind, input int val);
        push_ev(t0 + n, kind, val);
    endtask

    task automatic exp_head();
        ex(1, K_ACC, 0);
        ex(1, K_BUP, 0);
    endtask

    // K=4 inject pattern; the beats after the first are delayed by 'stall' cycles
    task automatic exp_feeds4(input int first, input int stall, input int count);
        int tab[11];
        tab = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E, 8'h3C, 8'h78, 8'hF0, 8'hE0, 8'hC0, 8'h80};
        for (int i = 0; i < count; i++) begin
            ex(first + i + ((i >= 1) ? stall : 0), K_FEED, tab[i]);
        end
    endtask

    task automatic exp_drain(input int first, input int step);
        for (int r = 0; r < 8; r++) ex(first + r * step, K_DRAIN, r);
    endtask

    task automatic exp_tail(input int done_c, input int shifts);
        ex(done_c, K_DONE, shifts);
        ex(done_c + 1, K_BDN, 0);
    endtask

    task automatic begin_pass(input int k);
        @(posedge clk);
        #1;
        t0      = cyc;
        start_i = 1'b1;
        k_len_i = 4'(k);
    endtask

    task automatic drive(input int st_a, input int st_b, input bit rtog,
                         input int abort_at, input int rst_at, input int ncyc);
        for (int n = 1; n <= ncyc; n++) begin
            @(posedge clk);
            #1;
            start_i     = 1'b0;
            src_valid_i = (n != st_a) && (n != st_b);
            out_ready_i = rtog ? ((n < 20) || (((n - 20) % 3) == 0)) : 1'b1;
            abort_i     = (n == abort_at);
            if (n == rst_at) rst_n = 1'b0;
        end
        abort_i     = 1'b0;
        src_valid_i = 1'b1;
        out_ready_i = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic nominal_pass();
        begin_pass(4);
        exp_head();
        exp_feeds4(2, 0, 11);
        exp_drain(20, 1);
        exp_tail(28, 18);
        drive(0, 0, 1'b0, 0, 0, 30);
        idle(2);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        rst_n       = 1'b1;
        start_i     = 1'b0;
        k_len_i     = 4'd0;
        abort_i     = 1'b0;
        src_valid_i = 1'b1;
        out_ready_i = 1'b1;

        // power-on reset: all outputs low
        #7;
        push_ev(cyc, K_RST, 0);
        rst_n = 1'b0;
        idle(2);
        #1 rst_n = 1'b1;
        idle(2);

        // nominal K=4 pass
        nominal_pass();

        // source stalls at cycles 3 and 4
        begin_pass(4);
        exp_head();
        exp_feeds4(2, 2, 11);
        exp_drain(22, 1);
        exp_tail(30, 18);
        drive(3, 4, 1'b0, 0, 0, 32);
        idle(2);

        // sink ready 1,0,0 repeating during drain
        begin_pass(4);
        exp_head();
        exp_feeds4(2, 0, 11);
        exp_drain(20, 3);
        exp_tail(42, 18);
        drive(0, 0, 1'b1, 0, 0, 44);
        idle(2);

        // K=0 start is ignored, then K=1
        begin_pass(0);
        drive(0, 0, 1'b0, 0, 0, 4);
        begin_pass(1);
        exp_head();
        for (int i = 0; i < 8; i++) ex(2 + i, K_FEED, 1 << i);
        exp_drain(17, 1);
        exp_tail(25, 15);
        drive(0, 0, 1'b0, 0, 0, 27);
        idle(2);

        // abort during the third flush cycle, then a clean pass
        begin_pass(4);
        exp_head();
        exp_feeds4(2, 0, 7);
        ex(9, K_BDN, 0);
        drive(0, 0, 1'b0, 8, 0, 11);
        idle(2);
        nominal_pass();

        // async reset after two drained rows; start held during reset
        begin_pass(4);
        exp_head();
        exp_feeds4(2, 0, 11);
        ex(20, K_DRAIN, 0);
        ex(21, K_DRAIN, 1);
        ex(22, K_RST, 0);
        ex(22, K_BDN, 0);
        drive(0, 0, 1'b0, 0, 22, 22);
        start_i = 1'b1;
        k_len_i = 4'd4;
        idle(3);
        #1;
        rst_n   = 1'b1;
        start_i = 1'b0;
        idle(2);
        nominal_pass();

        // final scoreboard drain check
        end_req = 1;
        for (int i = 0; i < 10 && !end_ack; i++) @(posedge clk);
        if (!end_ack) begin
            $display("FAIL end_check: got no monitor acknowledgement, required one within 10 cycles");
            $fatal(1, "monitor stalled");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
